ltl_cluster_sequencer: RTL and testbench

Controller placed in front of one LTL monitor cluster (ten property automata sharing an 8-bit symbol bus with `run`/`reset` controls). It buffers incoming trace symbols, issues them to the cluster one per cycle under an enable/clear state machine, latches the cluster's per-property violation hits into sticky pending flags, and serialises them onto a single round-robin report channel with a valid/ready handshake.

---
 rtl/ltl_cluster_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_ltl_cluster_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ltl_cluster_sequencer.sv
// Front-end controller for one LTL monitor cluster: buffers trace symbols, issues them
// under an enable/clear FSM, and serialises sticky violation hits onto a round-robin report channel.
module ltl_cluster_sequencer #(
    parameter int NUM_PROPS    = 10,
    parameter int SYM_W        = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 clear_req_i,
    input  logic                 sym_valid_i,
    output logic                 sym_ready_o,
    input  logic [SYM_W-1:0]     sym_data_i,
    output logic                 mon_run_o,
    output logic                 mon_reset_o,
    output logic [SYM_W-1:0]     mon_symbols_o,
    input  logic [NUM_PROPS-1:0] mon_hits_i,
    output logic                 rpt_valid_o,
    input  logic                 rpt_ready_i,
    output logic [3:0]           rpt_id_o,
    output logic [NUM_PROPS-1:0] pending_o,
    output logic                 busy_o,
    output logic [1:0]           state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and the report id/valid hold until that transfer.

    localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int CW = (CLEAR_CYCLES < 2) ? 1 : $clog2(CLEAR_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;

    logic [SYM_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;

    logic                 mon_run_q, mon_reset_q;
    logic [SYM_W-1:0]     mon_symbols_q;
    logic [NUM_PROPS-1:0] pending_q, pending_d;
    logic [3:0]           ptr_q, ptr_d;
    logic                 lock_q;
    logic [3:0]           lock_id_q;
    logic [3:0]           rr_grant;
    logic                 rr_found;

    logic flush, push, pop, hs;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= CW'(CLEAR_CYCLES);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (clear_req_i) begin
                    clr_cnt_d = CW'(CLEAR_CYCLES);
                end else if (clr_cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q - CW'(1);
                end
            end
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = CW'(CLEAR_CYCLES);
                end else if (enable_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_req_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = CW'(CLEAR_CYCLES);
                end else if (!enable_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = CW'(CLEAR_CYCLES);
            end
        endcase
    end

    assign state_o = state_q;

    // ---------------- symbol FIFO ----------------
    // Ready comes from the registered count only, so a full FIFO stays not-ready even while popping.
    assign sym_ready_o = (state_q != ST_CLEAR) && (count_q != (AW + 1)'(FIFO_DEPTH));
    assign flush       = clear_req_i && (state_q != ST_CLEAR);
    assign push        = sym_valid_i && sym_ready_o && !flush;
    assign pop         = (state_q == ST_RUN) && enable_i && !clear_req_i && (count_q != '0);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= sym_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + (AW + 1)'(1);
            else if (pop && !push) count_q <= count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            mon_run_q     <= 1'b0;
            mon_reset_q   <= 1'b1;
            mon_symbols_q <= '0;
        end else begin
            mon_run_q   <= pop;
            mon_reset_q <= (state_d == ST_CLEAR);
            if (pop) mon_symbols_q <= fifo_mem[rd_ptr_q];
        end
    end

    assign mon_run_o     = mon_run_q;
    assign mon_reset_o   = mon_reset_q;
    assign mon_symbols_o = mon_symbols_q;
    assign busy_o        = (count_q != '0) || (state_q == ST_CLEAR);

    // ---------------- hit capture and round-robin report ----------------
    always_comb begin
        rr_grant = 4'd0;
        rr_found = 1'b0;
        for (int k = 0; k < NUM_PROPS; k++) begin
            for (int i = 0; i < NUM_PROPS; i++) begin
                if (!rr_found && pending_q[i] && (((int'(ptr_q) + k) % NUM_PROPS) == i)) begin
                    rr_found = 1'b1;
                    rr_grant = 4'(i);
                end
            end
        end
    end

    assign rpt_valid_o = |pending_q;
    assign rpt_id_o    = lock_q ? lock_id_q : rr_grant;
    assign hs          = rpt_valid_o && rpt_ready_i;
    assign pending_o   = pending_q;

    // A hit arriving in the handshake cycle is applied after the clear, so it keeps the bit set.
    always_comb begin
        pending_d = pending_q;
        ptr_d     = ptr_q;
        for (int i = 0; i < NUM_PROPS; i++) begin
            if (hs && (rpt_id_o == 4'(i))) pending_d[i] = 1'b0;
        end
        if (state_q != ST_CLEAR) pending_d = pending_d | mon_hits_i;
        if (hs) ptr_d = (rpt_id_o == 4'(NUM_PROPS - 1)) ? 4'd0 : rpt_id_o + 4'd1;
        if (flush) begin
            pending_d = '0;
            ptr_d     = 4'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            pending_q <= '0;
            ptr_q     <= 4'd0;
            lock_q    <= 1'b0;
            lock_id_q <= 4'd0;
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            lock_q    <= rpt_valid_o && !rpt_ready_i && !flush;
            lock_id_q <= rpt_id_o;
        end
    end

endmodule

// File: tb/tb_ltl_cluster_sequencer.sv
// Directed bench for ltl_cluster_sequencer: hand-computed cycle-by-cycle expectations
// plus an expected-symbol queue for issue order.
module tb_ltl_cluster_sequencer;

    localparam int NP = 10;
    localparam int SW = 8;
    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i, enable_i, clear_req_i, sym_valid_i, rpt_ready_i;
    logic [SW-1:0] sym_data_i;
    logic [NP-1:0] mon_hits_i;
    logic          sym_ready_o, mon_run_o, mon_reset_o, rpt_valid_o, busy_o;
    logic [SW-1:0] mon_symbols_o;
    logic [3:0]    rpt_id_o;
    logic [NP-1:0] pending_o;
    logic [1:0]    state_o;

    ltl_cluster_sequencer #(.NUM_PROPS(NP), .SYM_W(SW), .FIFO_DEPTH(4), .CLEAR_CYCLES(2)) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .enable_i     (enable_i),
        .clear_req_i  (clear_req_i),
        .sym_valid_i  (sym_valid_i),
        .sym_ready_o  (sym_ready_o),
        .sym_data_i   (sym_data_i),
        .mon_run_o    (mon_run_o),
        .mon_reset_o  (mon_reset_o),
        .mon_symbols_o(mon_symbols_o),
        .mon_hits_i   (mon_hits_i),
        .rpt_valid_o  (rpt_valid_o),
        .rpt_ready_i  (rpt_ready_i),
        .rpt_id_o     (rpt_id_o),
        .pending_o    (pending_o),
        .busy_o       (busy_o),
        .state_o      (state_o)
    );

    // ---------------- scoreboard ----------------
    int n_vectors = 0;
    int n_miscompares = 0;
    logic [SW-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_issue(input string tag);
        if (mon_run_o) begin
            if (exp_q.size() == 0) check_eq({tag, "_unexpected_issue"}, 32'(mon_symbols_o), 32'hFFFF_FFFF);
            else check_eq(tag, 32'(mon_symbols_o), 32'(exp_q.pop_front()));
        end
    endtask

    int accepted;
    logic [SW-1:0] sym;

    initial begin
        reset_i = 1'b0; enable_i = 1'b1; clear_req_i = 1'b0; sym_valid_i = 1'b0;
        sym_data_i = '0; mon_hits_i = '0; rpt_ready_i = 1'b1;
        repeat (3) step();

        // reset state
        check_eq("rst_mon_reset", 32'(mon_reset_o), 1);
        check_eq("rst_mon_run", 32'(mon_run_o), 0);
        check_eq("rst_mon_symbols", 32'(mon_symbols_o), 0);
        check_eq("rst_sym_ready", 32'(sym_ready_o), 0);
        check_eq("rst_rpt_valid", 32'(rpt_valid_o), 0);
        check_eq("rst_rpt_id", 32'(rpt_id_o), 0);
        check_eq("rst_pending", 32'(pending_o), 0);
        check_eq("rst_busy", 32'(busy_o), 1);
        check_eq("rst_state", 32'(state_o), 32'(S_CLEAR));

        // reset release: two clear cycles, then ready
        reset_i = 1'b1;
        check_eq("rel0_mon_reset", 32'(mon_reset_o), 1);
        check_eq("rel0_sym_ready", 32'(sym_ready_o), 0);
        step();
        check_eq("rel1_mon_reset", 32'(mon_reset_o), 1);
        check_eq("rel1_sym_ready", 32'(sym_ready_o), 0);
        step();
        check_eq("rel2_mon_reset", 32'(mon_reset_o), 0);
        check_eq("rel2_sym_ready", 32'(sym_ready_o), 1);
        check_eq("rel2_state", 32'(state_o), 32'(S_IDLE));
        check_eq("rel2_busy", 32'(busy_o), 0);

        // back-to-back 0x11,0x22,0x33: issued at acceptance+2 on consecutive cycles
        sym_valid_i = 1'b1; sym_data_i = 8'h11; step();
        check_eq("b2b_state_run", 32'(state_o), 32'(S_RUN));
        check_eq("b2b_c3_run", 32'(mon_run_o), 0);
        sym_data_i = 8'h22; step();
        check_eq("b2b_c4_run", 32'(mon_run_o), 1);
        check_eq("b2b_c4_sym", 32'(mon_symbols_o), 32'h11);
        sym_data_i = 8'h33; step();
        sym_valid_i = 1'b0;
        check_eq("b2b_c5_run", 32'(mon_run_o), 1);
        check_eq("b2b_c5_sym", 32'(mon_symbols_o), 32'h22);
        step();
        check_eq("b2b_c6_run", 32'(mon_run_o), 1);
        check_eq("b2b_c6_sym", 32'(mon_symbols_o), 32'h33);
        step();
        check_eq("b2b_c7_run", 32'(mon_run_o), 0);
        check_eq("b2b_c7_hold", 32'(mon_symbols_o), 32'h33);
        check_eq("b2b_c7_busy", 32'(busy_o), 0);

        // fill with enable low: 5 offered, 4 accepted
        enable_i = 1'b0; step();
        check_eq("fill_state_idle", 32'(state_o), 32'(S_IDLE));
        accepted = 0;
        for (int i = 0; i < 5; i++) begin
            sym = 8'hA0 + 8'(i);
            sym_valid_i = 1'b1; sym_data_i = sym;
            if (sym_ready_o) begin
                accepted++;
                exp_q.push_back(sym);
            end
            step();
            check_issue("fill_no_issue");
        end
        sym_valid_i = 1'b0;
        check_eq("fill_accepted", 32'(accepted), 4);
        check_eq("fill_ready_low", 32'(sym_ready_o), 0);
        check_eq("fill_busy", 32'(busy_o), 1);

        enable_i = 1'b1; step();
        check_eq("drain_e1_ready", 32'(sym_ready_o), 0);
        check_eq("drain_e1_run", 32'(mon_run_o), 0);
        step();
        check_eq("drain_e2_ready", 32'(sym_ready_o), 1);
        check_eq("drain_e2_run", 32'(mon_run_o), 1);
        check_issue("drain_sym");
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("drain_run_hi", 32'(mon_run_o), 1);
            check_issue("drain_sym");
        end
        step();
        check_eq("drain_run_lo", 32'(mon_run_o), 0);
        check_eq("drain_queue_empty", 32'(exp_q.size()), 0);

        // hits 0b10_0000_0101 with ready high: ids 0,2,9
        rpt_ready_i = 1'b1; mon_hits_i = 10'b10_0000_0101; step();
        mon_hits_i = '0;
        check_eq("rr_pending", 32'(pending_o), 32'h205);
        check_eq("rr_v0", 32'(rpt_valid_o), 1);
        check_eq("rr_id0", 32'(rpt_id_o), 0);
        step();
        check_eq("rr_v1", 32'(rpt_valid_o), 1);
        check_eq("rr_id2", 32'(rpt_id_o), 2);
        step();
        check_eq("rr_v2", 32'(rpt_valid_o), 1);
        check_eq("rr_id9", 32'(rpt_id_o), 9);
        step();
        check_eq("rr_done", 32'(rpt_valid_o), 0);
        check_eq("rr_pending0", 32'(pending_o), 0);

        // lock: pending {3}, stalled, then hit 1 must not steal the grant
        rpt_ready_i = 1'b0; mon_hits_i = 10'(1 << 3); step();
        check_eq("lk_id3_a", 32'(rpt_id_o), 3);
        mon_hits_i = 10'(1 << 1); step();
        mon_hits_i = '0;
        check_eq("lk_pending", 32'(pending_o), 32'h00A);
        check_eq("lk_id3_b", 32'(rpt_id_o), 3);
        step();
        check_eq("lk_id3_c", 32'(rpt_id_o), 3);
        rpt_ready_i = 1'b1; step();
        check_eq("lk_wrap_v", 32'(rpt_valid_o), 1);
        check_eq("lk_wrap_id1", 32'(rpt_id_o), 1);
        step();
        check_eq("lk_done", 32'(rpt_valid_o), 0);

        // hit on id 5 in its own handshake cycle keeps the bit set
        rpt_ready_i = 1'b0; mon_hits_i = 10'(1 << 5); step();
        mon_hits_i = '0;
        check_eq("rh_id5", 32'(rpt_id_o), 5);
        rpt_ready_i = 1'b1; mon_hits_i = 10'(1 << 5); step();
        mon_hits_i = '0;
        check_eq("rh_pending5", 32'(pending_o), 32'h020);
        check_eq("rh_again_v", 32'(rpt_valid_o), 1);
        check_eq("rh_again_id", 32'(rpt_id_o), 5);
        step();
        check_eq("rh_done", 32'(rpt_valid_o), 0);

        // clear mid-RUN with 3 buffered symbols and pending {7}
        enable_i = 1'b0; step();
        for (int i = 0; i < 3; i++) begin
            sym_valid_i = 1'b1; sym_data_i = 8'hC0 + 8'(i); step();
        end
        sym_valid_i = 1'b0;
        rpt_ready_i = 1'b0; mon_hits_i = 10'(1 << 7); step();
        mon_hits_i = '0;
        check_eq("cl_pending7", 32'(pending_o), 32'h080);
        enable_i = 1'b1; step();
        check_eq("cl_state_run", 32'(state_o), 32'(S_RUN));
        check_eq("cl_busy_pre", 32'(busy_o), 1);
        clear_req_i = 1'b1; step();
        clear_req_i = 1'b0; enable_i = 1'b0;
        check_eq("cl_mon_run", 32'(mon_run_o), 0);
        check_eq("cl_rpt_valid", 32'(rpt_valid_o), 0);
        check_eq("cl_pending", 32'(pending_o), 0);
        check_eq("cl_rpt_id", 32'(rpt_id_o), 0);
        check_eq("cl_mon_reset1", 32'(mon_reset_o), 1);
        check_eq("cl_sym_ready", 32'(sym_ready_o), 0);
        check_eq("cl_state", 32'(state_o), 32'(S_CLEAR));
        step();
        check_eq("cl_mon_reset2", 32'(mon_reset_o), 1);
        check_eq("cl_busy_mid", 32'(busy_o), 1);
        step();
        check_eq("cl_mon_reset_off", 32'(mon_reset_o), 0);
        check_eq("cl_busy_after", 32'(busy_o), 0);
        check_eq("cl_ready_after", 32'(sym_ready_o), 1);
        check_eq("cl_state_idle", 32'(state_o), 32'(S_IDLE));
        check_eq("cl_mon_run_after", 32'(mon_run_o), 0);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
